armleocpu_store_queue: RTL and testbench

Store sequencer between the execute stage and the data bus.
- Accepts store requests.
- Performs alignment checking plus byte-lane mask and data shift generation.
- Buffers legal stores in a small in-order FIFO.
- Drains the FIFO to memory with one outstanding write at a time.
- Provides a word-address hazard lookup so the load path can stall on pending stores.

---
 rtl/armleocpu_store_queue_pkg.sv | 27 ++
 rtl/armleocpu_store_queue_if.sv | 42 ++++
 rtl/armleocpu_store_lanegen.sv | 41 ++++
 rtl/armleocpu_store_queue.sv | 175 +++++++++++++++++
 tb/tb_armleocpu_store_queue.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/armleocpu_store_queue_pkg.sv
// Shared definitions for the store queue and its lane generator.
// - Store type codes (byte/half/word; 2'b11 is illegal).
// - Drain FSM state encoding.
// - Queue entry layout: word address, lane-shifted data, byte strobes.
package armleocpu_store_queue_pkg;

  localparam logic [1:0] STORE_BYTE = 2'b00;
  localparam logic [1:0] STORE_HALF = 2'b01;
  localparam logic [1:0] STORE_WORD = 2'b10;

  localparam int unsigned EntryAddrW = 30;
  localparam int unsigned EntryDataW = 32;
  localparam int unsigned EntryStrbW = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitResp = 2'd2
  } sq_state_e;

  typedef struct packed {
    logic [EntryAddrW-1:0] addr;
    logic [EntryDataW-1:0] wdata;
    logic [EntryStrbW-1:0] wstrb;
  } sq_entry_t;

endpackage

// File: rtl/armleocpu_store_queue_if.sv
// Signal bundle between the store queue, the execute stage, the data bus and the load path.
// - master: the surrounding system (drives requests, bus handshakes, lookup address).
// - slave:  the store queue itself.
interface armleocpu_store_queue_if;
  // Execute-stage request and response
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_type;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_misaligned;
  logic        rsp_unknown_type;
  // Data bus write channel
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_err;
  logic        bus_err;
  logic [31:0] bus_err_addr;
  // Load-path hazard lookup and status
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic        empty;

  modport master (
    output req_valid, req_addr, req_type, req_data, mem_ready, mem_resp_valid, mem_resp_err,
           lookup_addr,
    input  req_ready, rsp_valid, rsp_misaligned, rsp_unknown_type, mem_valid, mem_addr,
           mem_wdata, mem_wstrb, bus_err, bus_err_addr, lookup_hit, empty
  );

  modport slave (
    input  req_valid, req_addr, req_type, req_data, mem_ready, mem_resp_valid, mem_resp_err,
           lookup_addr,
    output req_ready, rsp_valid, rsp_misaligned, rsp_unknown_type, mem_valid, mem_addr,
           mem_wdata, mem_wstrb, bus_err, bus_err_addr, lookup_hit, empty
  );
endinterface

// File: rtl/armleocpu_store_lanegen.sv
// Combinational store lane generator.
// Ports:
//   addr_lo      - byte offset within the word (address bits [1:0])
//   store_type   - STORE_BYTE / STORE_HALF / STORE_WORD, 2'b11 illegal
//   data         - unshifted, LSB-aligned store data
//   mask         - byte enables for the addressed lanes
//   wdata        - data shifted into its byte lanes
//   misaligned   - half on odd byte, or word not on a word boundary
//   unknown_type - store_type is 2'b11
module armleocpu_store_lanegen
  import armleocpu_store_queue_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  store_type,
  input  logic [31:0] data,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        unknown_type
);

  always_comb begin
    mask         = 4'b0000;
    misaligned   = 1'b0;
    unknown_type = 1'b0;
    wdata        = data << {addr_lo, 3'b000};
    unique case (store_type)
      STORE_BYTE: mask = 4'b0001 << addr_lo;
      STORE_HALF: begin
        mask       = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      STORE_WORD: begin
        mask       = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: unknown_type = 1'b1;
    endcase
  end

endmodule

// File: rtl/armleocpu_store_queue.sv
// In-order store queue between execute and the data bus.
// Legal stores are lane-shifted and buffered; the drain FSM writes them out one at a time,
// keeping the head entry visible to the load-path lookup until its completion arrives.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   sq         - slave side of armleocpu_store_queue_if (request/response, bus write,
//                error report, hazard lookup, empty status)
// Parameters:
//   DEPTH_LOG2 - log2 of queue entries, 1..4
// Optional feature: define ARMLEOCPU_STORE_QUEUE_MERGE_EN to let a legal store merge into the
// youngest entry when it targets the same word and that entry is not being written out.
module armleocpu_store_queue
  import armleocpu_store_queue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  armleocpu_store_queue_if.slave sq
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  sq_entry_t entries_q [Depth];
  ptr_t      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t      count_q, count_d;
  sq_state_e state_q, state_d;

  logic        rsp_valid_q, rsp_misaligned_q, rsp_unknown_type_q;
  logic        bus_err_q;
  logic [31:0] bus_err_addr_q;

  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic        lane_misaligned, lane_unknown;
  logic        legal, full, merge_possible, accept, push, pop;

  armleocpu_store_lanegen u_lanegen (
    .addr_lo      (sq.req_addr[1:0]),
    .store_type   (sq.req_type),
    .data         (sq.req_data),
    .mask         (lane_mask),
    .wdata        (lane_data),
    .misaligned   (lane_misaligned),
    .unknown_type (lane_unknown)
  );

  assign legal = !lane_misaligned && !lane_unknown;
  assign full  = (count_q == cnt_t'(Depth));

`ifdef ARMLEOCPU_STORE_QUEUE_MERGE_EN
  ptr_t young_ptr;
  logic merge;
  assign young_ptr = wr_ptr_q - ptr_t'(1);
  // A lone entry is the head; once the FSM has left IDLE it is on (or headed to) the bus.
  assign merge_possible = legal && (count_q != '0) &&
                          !((count_q == cnt_t'(1)) && (state_q != StIdle)) &&
                          (entries_q[young_ptr].addr == sq.req_addr[31:2]);
  assign merge = accept && merge_possible;
`else
  assign merge_possible = 1'b0;
`endif

  assign sq.req_ready = !full || merge_possible;
  assign accept       = sq.req_valid && sq.req_ready;
  assign push         = accept && legal && !merge_possible;
  assign pop          = (state_q == StWaitResp) && sq.mem_resp_valid;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (count_q != '0) state_d = StIssue;
      StIssue:    if (sq.mem_ready) state_d = StWaitResp;
      StWaitResp: if (sq.mem_resp_valid) state_d = (count_d != '0) ? StIssue : StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM: outputs; bus fields always track the head so they hold steady while stalled
  always_comb begin
    sq.mem_valid = (state_q == StIssue);
    sq.mem_addr  = {entries_q[rd_ptr_q].addr, 2'b00};
    sq.mem_wdata = entries_q[rd_ptr_q].wdata;
    sq.mem_wstrb = entries_q[rd_ptr_q].wstrb;
    sq.empty     = (count_q == '0) && (state_q == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      count_q            <= '0;
      rsp_valid_q        <= 1'b0;
      rsp_misaligned_q   <= 1'b0;
      rsp_unknown_type_q <= 1'b0;
      bus_err_q          <= 1'b0;
      bus_err_addr_q     <= '0;
    end else begin
      rd_ptr_q           <= rd_ptr_d;
      wr_ptr_q           <= wr_ptr_d;
      count_q            <= count_d;
      rsp_valid_q        <= accept;
      rsp_misaligned_q   <= accept && lane_misaligned;
      rsp_unknown_type_q <= accept && lane_unknown;
      bus_err_q          <= pop && sq.mem_resp_err;
      if (pop && sq.mem_resp_err) begin
        bus_err_addr_q <= {entries_q[rd_ptr_q].addr, 2'b00};
      end
    end
  end

  // Entry storage needs no reset: only entries inside [rd_ptr, rd_ptr+count) are ever used.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wr_ptr_q] <= '{addr: sq.req_addr[31:2], wdata: lane_data, wstrb: lane_mask};
    end
`ifdef ARMLEOCPU_STORE_QUEUE_MERGE_EN
    else if (merge) begin
      entries_q[young_ptr].wstrb <= entries_q[young_ptr].wstrb | lane_mask;
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_mask[b]) entries_q[young_ptr].wdata[8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
`endif
  end

  assign sq.rsp_valid        = rsp_valid_q;
  assign sq.rsp_misaligned   = rsp_misaligned_q;
  assign sq.rsp_unknown_type = rsp_unknown_type_q;
  assign sq.bus_err          = bus_err_q;
  assign sq.bus_err_addr     = bus_err_addr_q;

  // Hazard lookup over every counted entry, including the one in flight.
  always_comb begin
    ptr_t off;
    sq.lookup_hit = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      off = ptr_t'(i) - rd_ptr_q;
      if ((cnt_t'(off) < count_q) && (entries_q[i].addr == sq.lookup_addr[31:2])) begin
        sq.lookup_hit = 1'b1;
      end
    end
  end

  // Lookups compare whole words; the byte offset is irrelevant.
  logic unused_lookup_lo;
  assign unused_lookup_lo = ^sq.lookup_addr[1:0];

endmodule

// File: tb/tb_armleocpu_store_queue.sv
module tb_armleocpu_store_queue;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  armleocpu_store_queue_if sq_if ();

  armleocpu_store_queue #(
    .DEPTH_LOG2 (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [1:0] t,
                         input logic [31:0] d);
    sq_if.req_valid = v;
    sq_if.req_addr  = a;
    sq_if.req_type  = t;
    sq_if.req_data  = d;
  endtask

  logic [31:0] got_addr [5];
  logic [31:0] got_data [5];
  int          n;
  int          nerr;
  logic [31:0] eaddr;
  logic [31:0] last_addr;
  logic        acc5;
  logic        will_accept;

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    set_req(1'b0, 32'h0, 2'b00, 32'h0);
    sq_if.mem_ready      = 1'b0;
    sq_if.mem_resp_valid = 1'b0;
    sq_if.mem_resp_err   = 1'b0;
    sq_if.lookup_addr    = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_empty", sq_if.empty, 1);
    chk("rst_mem_valid", sq_if.mem_valid, 0);
    chk("rst_rsp_valid", sq_if.rsp_valid, 0);
    chk("rst_bus_err", sq_if.bus_err, 0);
    chk("rst_bus_err_addr", sq_if.bus_err_addr, 0);
    chk("rst_req_ready", sq_if.req_ready, 1);

    // Byte store at 0x1003
    set_req(1'b1, 32'h0000_1003, 2'b00, 32'h0000_00AB);
    tick();
    sq_if.req_valid = 1'b0;
    chk("b_rsp_valid", sq_if.rsp_valid, 1);
    chk("b_rsp_mis", sq_if.rsp_misaligned, 0);
    chk("b_rsp_unk", sq_if.rsp_unknown_type, 0);
    chk("b_not_empty", sq_if.empty, 0);
    tick();
    chk("b_mem_valid", sq_if.mem_valid, 1);
    chk("b_mem_addr", sq_if.mem_addr, 32'h0000_1000);
    chk("b_mem_wstrb", sq_if.mem_wstrb, 4'b1000);
    chk("b_mem_wdata", sq_if.mem_wdata, 32'hAB00_0000);
    chk("b_rsp_pulse_end", sq_if.rsp_valid, 0);
    sq_if.mem_ready = 1'b1;
    tick();
    sq_if.mem_ready = 1'b0;
    chk("b_wait_no_valid", sq_if.mem_valid, 0);
    sq_if.mem_resp_valid = 1'b1;
    tick();
    sq_if.mem_resp_valid = 1'b0;
    chk("b_empty_after", sq_if.empty, 1);

    // Misaligned half, then unknown type
    set_req(1'b1, 32'h0000_2001, 2'b01, 32'h0000_1234);
    tick();
    sq_if.req_valid = 1'b0;
    chk("h_rsp_valid", sq_if.rsp_valid, 1);
    chk("h_rsp_mis", sq_if.rsp_misaligned, 1);
    chk("h_rsp_unk", sq_if.rsp_unknown_type, 0);
    chk("h_empty", sq_if.empty, 1);
    set_req(1'b1, 32'h0000_2000, 2'b11, 32'h0000_1234);
    tick();
    sq_if.req_valid = 1'b0;
    chk("h_no_bus", sq_if.mem_valid, 0);
    chk("u_rsp_valid", sq_if.rsp_valid, 1);
    chk("u_rsp_unk", sq_if.rsp_unknown_type, 1);
    chk("u_rsp_mis", sq_if.rsp_misaligned, 0);
    tick();
    chk("u_empty", sq_if.empty, 1);
    chk("u_no_bus", sq_if.mem_valid, 0);

    // Fill with four words while the bus stalls, fifth held off
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 32'h0000_0100 + 32'(4 * i), 2'b10, 32'hA0 + 32'(i));
      tick();
    end
    set_req(1'b1, 32'h0000_0110, 2'b10, 32'hA4);
    #1;
    chk("full_ready0", sq_if.req_ready, 0);
    tick();
    tick();
    chk("full_ready1", sq_if.req_ready, 0);
    chk("full_head_valid", sq_if.mem_valid, 1);
    chk("full_head_addr", sq_if.mem_addr, 32'h0000_0100);
    sq_if.mem_ready      = 1'b1;
    sq_if.mem_resp_valid = 1'b1;
    n    = 0;
    acc5 = 1'b0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      will_accept = sq_if.req_valid && sq_if.req_ready;
      if (sq_if.mem_valid) begin
        got_addr[n] = sq_if.mem_addr;
        got_data[n] = sq_if.mem_wdata;
        n++;
      end
      tick();
      if (will_accept) begin
        sq_if.req_valid = 1'b0;
        acc5            = 1'b1;
      end
    end
    tick();
    sq_if.mem_ready      = 1'b0;
    sq_if.mem_resp_valid = 1'b0;
    tick();
    chk("drain_count", n, 5);
    chk("fifth_accepted", acc5, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_addr%0d", i), got_addr[i], 32'h0000_0100 + 32'(4 * i));
      chk($sformatf("drain_data%0d", i), got_data[i], 32'hA0 + 32'(i));
    end
    chk("drain_empty", sq_if.empty, 1);

    // Error on the second of three stores
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'h0000_0500 + 32'(4 * i), 2'b10, 32'hC0 + 32'(i));
      tick();
    end
    sq_if.req_valid      = 1'b0;
    sq_if.mem_ready      = 1'b1;
    sq_if.mem_resp_valid = 1'b1;
    sq_if.mem_resp_err   = 1'b0;
    n         = 0;
    nerr      = 0;
    eaddr     = '0;
    last_addr = '0;
    for (int c = 0; c < 14; c++) begin
      if (sq_if.mem_valid) begin
        n++;
        sq_if.mem_resp_err = (n == 2);
        if (n == 3) last_addr = sq_if.mem_addr;
      end
      if (sq_if.bus_err) begin
        nerr++;
        eaddr = sq_if.bus_err_addr;
      end
      tick();
    end
    sq_if.mem_ready      = 1'b0;
    sq_if.mem_resp_valid = 1'b0;
    sq_if.mem_resp_err   = 1'b0;
    tick();
    chk("err_writes", n, 3);
    chk("err_pulses", nerr, 1);
    chk("err_addr_seen", eaddr, 32'h0000_0504);
    chk("err_third_written", last_addr, 32'h0000_0508);
    chk("err_empty", sq_if.empty, 1);
    chk("err_addr_held", sq_if.bus_err_addr, 32'h0000_0504);

    // Hazard lookup across queue, issue and in-flight
    sq_if.lookup_addr = 32'h0000_3006;
    #1;
    chk("lk_miss_before", sq_if.lookup_hit, 0);
    set_req(1'b1, 32'h0000_3004, 2'b10, 32'h55);
    tick();
    sq_if.req_valid = 1'b0;
    #1;
    chk("lk_hit_queued", sq_if.lookup_hit, 1);
    tick();
    chk("lk_issue", sq_if.mem_valid, 1);
    chk("lk_hit_issue", sq_if.lookup_hit, 1);
    sq_if.mem_ready = 1'b1;
    tick();
    sq_if.mem_ready = 1'b0;
    #1;
    chk("lk_wait", sq_if.mem_valid, 0);
    chk("lk_hit_inflight", sq_if.lookup_hit, 1);
    sq_if.mem_resp_valid = 1'b1;
    tick();
    sq_if.mem_resp_valid = 1'b0;
    #1;
    chk("lk_miss_after", sq_if.lookup_hit, 0);
    chk("lk_empty", sq_if.empty, 1);

    // Reset while waiting for a response; a late completion must be ignored
    set_req(1'b1, 32'h0000_3004, 2'b10, 32'h66);
    tick();
    sq_if.req_valid = 1'b0;
    tick();
    sq_if.mem_ready = 1'b1;
    tick();
    sq_if.mem_ready = 1'b0;
    rst_n           = 1'b0;
    tick();
    chk("mr_mem_valid", sq_if.mem_valid, 0);
    chk("mr_empty", sq_if.empty, 1);
    chk("mr_rsp_valid", sq_if.rsp_valid, 0);
    chk("mr_bus_err", sq_if.bus_err, 0);
    chk("mr_bus_err_addr", sq_if.bus_err_addr, 0);
    chk("mr_lookup", sq_if.lookup_hit, 0);
    chk("mr_ready", sq_if.req_ready, 1);
    rst_n                = 1'b1;
    sq_if.mem_resp_valid = 1'b1;
    sq_if.mem_resp_err   = 1'b1;
    tick();
    sq_if.mem_resp_valid = 1'b0;
    sq_if.mem_resp_err   = 1'b0;
    chk("late_bus_err", sq_if.bus_err, 0);
    chk("late_empty", sq_if.empty, 1);
    tick();
    chk("late_bus_err2", sq_if.bus_err, 0);

`ifdef ARMLEOCPU_STORE_QUEUE_MERGE_EN
    // Two bytes to the same word merge into one write
    set_req(1'b1, 32'h0000_4000, 2'b00, 32'h11);
    tick();
    set_req(1'b1, 32'h0000_4002, 2'b00, 32'h22);
    tick();
    sq_if.req_valid = 1'b0;
    chk("mg_issue", sq_if.mem_valid, 1);
    chk("mg_addr", sq_if.mem_addr, 32'h0000_4000);
    chk("mg_wstrb", sq_if.mem_wstrb, 4'b0101);
    chk("mg_wdata", sq_if.mem_wdata, 32'h0022_0011);
    sq_if.mem_ready = 1'b1;
    tick();
    sq_if.mem_ready      = 1'b0;
    sq_if.mem_resp_valid = 1'b1;
    tick();
    sq_if.mem_resp_valid = 1'b0;
    chk("mg_single_entry", sq_if.empty, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
